red_pitaya_pid_mimo_tdm: RTL and testbench

Parametrised N×N MIMO PID controller for the Red Pitaya signal-processing fabric. It evaluates all NCH² PID paths (input i → output o) through one shared, time-multiplexed arithmetic pipeline per sample strobe. It adds anti-windup integrator saturation, per-path enables, frame-coherent coefficient updates and overrun detection. It sits between the ADC and DAC data paths, with a local register port driven by the bus bridge.

---
 rtl/red_pitaya_pid_mimo_tdm.sv | 255 +++++++++++++++++++++++++
 tb/tb_red_pitaya_pid_mimo_tdm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pid_mimo_tdm.sv
// NCH x NCH MIMO PID controller: every input->output path is evaluated in turn through one
// shared 4-stage pipeline (fetch/error, multiply, shift/sum/integrate, saturate/accumulate).
module red_pitaya_pid_mimo_tdm #(
   parameter int NCH = 2,
   parameter int DW  = 14,
   parameter int IW  = 32,
   parameter int PSR = 12,
   parameter int ISR = 18,
   parameter int DSR = 10,
   parameter int AW  = 12
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                smp_i,
   input  logic [NCH*DW-1:0]   dat_i,
   output logic [NCH*DW-1:0]   dat_o,
   output logic                dat_vld_o,
   output logic                busy_o,
   input  logic                cfg_wen_i,
   input  logic [AW-1:0]       cfg_addr_i,
   input  logic [31:0]         cfg_wdata_i,
   output logic [31:0]         cfg_rdata_o
);
   localparam int NP  = NCH * NCH;
   localparam int KW  = (NP > 1) ? $clog2(NP) : 1;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW  = 2 * DW + 1;
   localparam int DPW = 2 * DW + 2;
   localparam int SW  = ((IW > DPW) ? IW : DPW) + 2;
   localparam int AXW = DW + $clog2(NCH) + 1;
   localparam logic signed [SW-1:0] L_DMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] L_DMIN = ~L_DMAX;

   function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
      if (v > L_DMAX)      return L_DMAX[DW-1:0];
      else if (v < L_DMIN) return L_DMIN[DW-1:0];
      else                 return v[DW-1:0];
   endfunction

   // ---------------- register file ----------------
   logic [NP-1:0]        r_irst, r_en;
   logic                 r_ovr;
   logic [31:0]          r_rdata;
   logic signed [DW-1:0] r_sp [NP];
   logic signed [DW-1:0] r_kp [NP];
   logic signed [DW-1:0] r_ki [NP];
   logic signed [DW-1:0] r_kd [NP];
   logic                 r_busy;

   logic [AW-5:0]        w_blk;
   logic                 w_hit;
   logic [KW-1:0]        w_bk;
   logic [31:0]          w_rdata;
   logic                 w_unused;

   assign w_unused = ^{cfg_wdata_i, w_blk};

   always_comb begin
      w_blk   = cfg_addr_i[AW-1:4] - (AW-4)'(1);
      w_hit   = (cfg_addr_i[AW-1:4] != '0) && (w_blk < (AW-4)'(NP)) && (cfg_addr_i[1:0] == 2'b00);
      w_bk    = w_blk[KW-1:0];
      w_rdata = '0;
      if (cfg_addr_i == AW'(0))      w_rdata[NP-1:0] = r_irst;
      else if (cfg_addr_i == AW'(4)) w_rdata[NP-1:0] = r_en;
      else if (cfg_addr_i == AW'(8)) w_rdata[0]      = r_ovr;
      else if (w_hit) begin
         case (cfg_addr_i[3:2])
            2'd0:    w_rdata[DW-1:0] = r_sp[w_bk];
            2'd1:    w_rdata[DW-1:0] = r_kp[w_bk];
            2'd2:    w_rdata[DW-1:0] = r_ki[w_bk];
            default: w_rdata[DW-1:0] = r_kd[w_bk];
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_irst  <= '1;
         r_en    <= '0;
         r_ovr   <= 1'b0;
         r_rdata <= '0;
         for (int k = 0; k < NP; k++) begin
            r_sp[k] <= '0;
            r_kp[k] <= '0;
            r_ki[k] <= '0;
            r_kd[k] <= '0;
         end
      end else begin
         r_rdata <= w_rdata;
         if (cfg_wen_i) begin
            if (cfg_addr_i == AW'(0)) r_irst <= cfg_wdata_i[NP-1:0];
            if (cfg_addr_i == AW'(4)) r_en   <= cfg_wdata_i[NP-1:0];
            if (w_hit) begin
               case (cfg_addr_i[3:2])
                  2'd0:    r_sp[w_bk] <= cfg_wdata_i[DW-1:0];
                  2'd1:    r_kp[w_bk] <= cfg_wdata_i[DW-1:0];
                  2'd2:    r_ki[w_bk] <= cfg_wdata_i[DW-1:0];
                  default: r_kd[w_bk] <= cfg_wdata_i[DW-1:0];
               endcase
            end
         end
         // a dropped strobe outranks a same-cycle clear
         if (smp_i && r_busy)
            r_ovr <= 1'b1;
         else if (cfg_wen_i && (cfg_addr_i == AW'(8)) && cfg_wdata_i[0])
            r_ovr <= 1'b0;
      end
   end

   // ---------------- datapath ----------------
   // smp_i is taken only while busy_o is low; dat_vld_o is a one-cycle pulse with no backpressure.
   logic                  r_iss, r_vld;
   logic [KW-1:0]         r_k;
   logic [CHW-1:0]        r_si, r_so;
   logic signed [DW-1:0]  r_x [NCH];
   logic signed [IW-1:0]  r_int [NP];
   logic signed [DW:0]    r_eprev [NP];
   logic signed [DW-1:0]  r_sh_sp [NP];
   logic signed [DW-1:0]  r_sh_kp [NP];
   logic signed [DW-1:0]  r_sh_ki [NP];
   logic signed [DW-1:0]  r_sh_kd [NP];
   logic [NP-1:0]         r_sh_en, r_sh_irst;
   logic signed [AXW-1:0] r_acc [NCH];
   logic [NCH*DW-1:0]     r_dat;

   logic                  r_p1_vld, r_p2_vld, r_p3_vld;
   logic [KW-1:0]         r_p1_k, r_p2_k, r_p3_k;
   logic [CHW-1:0]        r_p1_o, r_p2_o, r_p3_o;
   logic signed [DW:0]    r_p1_e;
   logic signed [DW+1:0]  r_p1_de;
   logic signed [PW-1:0]  r_p2_pm, r_p2_im;
   logic signed [DPW-1:0] r_p2_dm;
   logic signed [SW-1:0]  r_p3_sum;

   logic                  w_accept;
   logic signed [DW:0]    w_e;
   logic signed [DW+1:0]  w_de;
   logic signed [IW:0]    w_int_sum;
   logic signed [IW-1:0]  w_int_new;
   logic signed [SW-1:0]  w_sum;
   logic signed [DW-1:0]  w_y;
   logic signed [AXW-1:0] w_acc_nxt [NCH];

   assign w_accept    = smp_i & ~r_busy;
   assign dat_o       = r_dat;
   assign dat_vld_o   = r_vld;
   assign busy_o      = r_busy;
   assign cfg_rdata_o = r_rdata;

   always_comb begin
      w_e  = (DW+1)'(r_sh_sp[r_k]) - (DW+1)'(r_x[r_si]);
      w_de = (DW+2)'(w_e) - (DW+2)'(r_eprev[r_k]);
   end

   always_comb begin
      w_int_sum = (IW+1)'(r_int[r_p2_k]) + (IW+1)'(r_p2_im);
      if (w_int_sum[IW] != w_int_sum[IW-1])
         w_int_new = w_int_sum[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
      else
         w_int_new = w_int_sum[IW-1:0];
      if (r_sh_irst[r_p2_k]) w_int_new = '0;
      // I uses the freshly updated integrator value
      w_sum = SW'(r_p2_pm >>> PSR) + SW'(w_int_new >>> ISR) + SW'(r_p2_dm >>> DSR);
   end

   always_comb begin
      w_y = sat_dw(r_p3_sum);
      if (!r_sh_en[r_p3_k]) w_y = '0;
      for (int o = 0; o < NCH; o++) w_acc_nxt[o] = r_acc[o];
      w_acc_nxt[r_p3_o] = r_acc[r_p3_o] + AXW'(w_y);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_busy <= 1'b0; r_iss <= 1'b0; r_vld <= 1'b0;
         r_k <= '0; r_si <= '0; r_so <= '0;
         r_sh_en <= '0; r_sh_irst <= '1; r_dat <= '0;
         r_p1_vld <= 1'b0; r_p2_vld <= 1'b0; r_p3_vld <= 1'b0;
         r_p1_k <= '0; r_p2_k <= '0; r_p3_k <= '0;
         r_p1_o <= '0; r_p2_o <= '0; r_p3_o <= '0;
         r_p1_e <= '0; r_p1_de <= '0;
         r_p2_pm <= '0; r_p2_im <= '0; r_p2_dm <= '0; r_p3_sum <= '0;
         for (int c = 0; c < NCH; c++) begin
            r_x[c]   <= '0;
            r_acc[c] <= '0;
         end
         for (int k = 0; k < NP; k++) begin
            r_int[k] <= '0; r_eprev[k] <= '0;
            r_sh_sp[k] <= '0; r_sh_kp[k] <= '0; r_sh_ki[k] <= '0; r_sh_kd[k] <= '0;
         end
      end else begin
         r_vld    <= 1'b0;
         r_p1_vld <= r_iss;
         r_p2_vld <= r_p1_vld;
         r_p3_vld <= r_p2_vld;

         if (r_iss) begin
            r_eprev[r_k] <= w_e;
            r_p1_k  <= r_k;
            r_p1_o  <= r_so;
            r_p1_e  <= w_e;
            r_p1_de <= w_de;
            r_k     <= r_k + KW'(1);
            if (r_k == KW'(NP-1)) r_iss <= 1'b0;
            if (r_si == CHW'(NCH-1)) begin
               r_si <= '0;
               r_so <= r_so + CHW'(1);
            end else begin
               r_si <= r_si + CHW'(1);
            end
         end

         if (w_accept) begin
            r_busy <= 1'b1; r_iss <= 1'b1;
            r_k <= '0; r_si <= '0; r_so <= '0;
            r_sh_en <= r_en; r_sh_irst <= r_irst;
            for (int c = 0; c < NCH; c++) begin
               r_x[c]   <= dat_i[c*DW +: DW];
               r_acc[c] <= '0;
            end
            for (int k = 0; k < NP; k++) begin
               r_sh_sp[k] <= r_sp[k]; r_sh_kp[k] <= r_kp[k];
               r_sh_ki[k] <= r_ki[k]; r_sh_kd[k] <= r_kd[k];
            end
         end else if (r_vld) begin
            r_busy <= 1'b0;
         end

         if (r_p1_vld) begin
            r_p2_k  <= r_p1_k;
            r_p2_o  <= r_p1_o;
            r_p2_pm <= PW'(r_sh_kp[r_p1_k]) * PW'(r_p1_e);
            r_p2_im <= PW'(r_sh_ki[r_p1_k]) * PW'(r_p1_e);
            r_p2_dm <= DPW'(r_sh_kd[r_p1_k]) * DPW'(r_p1_de);
         end

         if (r_p2_vld) begin
            r_int[r_p2_k] <= w_int_new;
            r_p3_k   <= r_p2_k;
            r_p3_o   <= r_p2_o;
            r_p3_sum <= w_sum;
         end

         if (r_p3_vld && !w_accept) begin
            r_acc[r_p3_o] <= w_acc_nxt[r_p3_o];
            if (r_p3_k == KW'(NP-1)) begin
               r_vld <= 1'b1;
               for (int c = 0; c < NCH; c++)
                  r_dat[c*DW +: DW] <= sat_dw(SW'(w_acc_nxt[c]));
            end
         end
      end
   end

endmodule

// File: tb/tb_red_pitaya_pid_mimo_tdm.sv
// Directed bench for red_pitaya_pid_mimo_tdm (NCH=2): frames push expected outputs into a
// queue, an independent monitor pops and compares on every dat_vld_o pulse.
module tb_red_pitaya_pid_mimo_tdm;
   localparam int NCH = 2;
   localparam int DW  = 14;
   localparam int AW  = 12;
   localparam int OW  = NCH * DW;
   localparam int LAT = NCH * NCH + 4;

   logic          clk, rstn, smp, wen, vld, busy;
   logic [OW-1:0] dat_in, dat_out;
   logic [AW-1:0] addr;
   logic [31:0]   wdata, rdata;

   logic [OW-1:0] exp_q[$];
   int            acc_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_vld = 0;
   int            cyc   = 0;
   int            v0;
   logic [OW-1:0] m_exp;
   int            m_acc;

   red_pitaya_pid_mimo_tdm dut (
      .clk_i(clk), .rstn_i(rstn), .smp_i(smp), .dat_i(dat_in), .dat_o(dat_out),
      .dat_vld_o(vld), .busy_o(busy), .cfg_wen_i(wen), .cfg_addr_i(addr),
      .cfg_wdata_i(wdata), .cfg_rdata_o(rdata)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (vld) begin
         n_vld++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_vld: dat_o=%h with no frame pending", dat_out);
         end else begin
            m_exp = exp_q.pop_front();
            m_acc = acc_q.pop_front();
            if (dat_out !== m_exp) begin
               n_bad++;
               $display("FAIL frame_out: got=%h exp=%h", dat_out, m_exp);
            end
            n_cmp++;
            if (cyc - m_acc != LAT) begin
               n_bad++;
               $display("FAIL frame_latency: got=%0d exp=%0d", cyc - m_acc, LAT);
            end
         end
      end
   end

   // driver tasks
   function automatic logic [OW-1:0] pk(input int d0, input int d1);
      logic [31:0] a, b;
      a = d0;
      b = d1;
      return {b[DW-1:0], a[DW-1:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wen = 1'b1; addr = AW'(a); wdata = d;
      tick();
      wen = 1'b0;
   endtask

   task automatic rd_chk(input int a, input logic [31:0] exp, input string nm);
      addr = AW'(a);
      tick();
      check(nm, rdata, exp);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 30) begin
         tick();
         n++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL busy_timeout: busy_o still high after %0d cycles", n);
      end
   endtask

   task automatic frame(input int d0, input int d1, input int e0, input int e1);
      exp_q.push_back(pk(e0, e1));
      acc_q.push_back(cyc);
      dat_in = pk(d0, d1);
      smp = 1'b1;
      tick();
      smp = 1'b0;
      wait_idle();
   endtask

   // stimulus
   initial begin
      rstn = 1'b0; smp = 1'b0; wen = 1'b0; addr = '0; wdata = '0; dat_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dat_o", 32'(dat_out), 32'h0);
      check("rst_vld", 32'(vld), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      rstn = 1'b1;
      tick();
      rd_chk(32'h00, 32'hF, "rd_irst_rst");
      rd_chk(32'h04, 32'h0, "rd_en_rst");
      rd_chk(32'h08, 32'h0, "rd_status_rst");

      // proportional path 0 -> out0
      wr(32'h04, 32'h1);
      wr(32'h14, 32'd4096);
      rd_chk(32'h14, 32'h1000, "rd_kp0");
      frame(1000, 0, -1000, 0);

      // single-path saturation
      wr(32'h10, 32'd8191);
      wr(32'h14, 32'd8191);
      rd_chk(32'h10, 32'h1FFF, "rd_sp0");
      frame(-8192, 0, 8191, 0);

      // summed saturation, paths 0 and 1 both feed out0
      wr(32'h10, 32'd0);
      wr(32'h14, 32'd4096);
      wr(32'h24, 32'd4096);
      wr(32'h04, 32'h3);
      frame(-6000, -6000, 8191, 0);
      frame(6000, 6000, -8192, 0);

      // read-back truncation and unmapped space
      wr(32'h20, 32'hFFFF_FFFB);
      rd_chk(32'h20, 32'h3FFB, "rd_sp1_zext");
      wr(32'h0C, 32'h1234);
      rd_chk(32'h0C, 32'h0, "rd_unmapped_0c");
      wr(32'h50, 32'h55);
      rd_chk(32'h50, 32'h0, "rd_unmapped_50");

      // routing: path 2 is input 0 -> output 1
      wr(32'h04, 32'h4);
      wr(32'h30, 32'd100);
      wr(32'h34, 32'd2048);
      frame(300, 0, 0, -100);

      // derivative on path 3 (input 1 -> output 1)
      wr(32'h04, 32'h8);
      wr(32'h4C, 32'd1024);
      frame(0, -400, 0, 400);
      frame(0, -400, 0, 0);

      // integrator on path 0
      wr(32'h04, 32'h1);
      wr(32'h14, 32'd0);
      wr(32'h18, 32'd4096);
      wr(32'h10, 32'd64);
      wr(32'h00, 32'hE);
      for (int n = 1; n <= 10; n++) frame(0, 0, n, 0);
      wr(32'h00, 32'hF);
      frame(0, 0, 0, 0);

      // overrun and shadow snapshot
      wr(32'h14, 32'd4096);
      v0 = n_vld;
      exp_q.push_back(pk(64, 0));
      acc_q.push_back(cyc);
      dat_in = pk(0, 0);
      smp = 1'b1;
      tick();
      smp = 1'b0;
      tick();
      wen = 1'b1; addr = AW'(32'h14); wdata = 32'd8191;
      tick();
      wen = 1'b0;
      smp = 1'b1;
      tick();
      smp = 1'b0;
      wait_idle();
      tick();
      check("ovr_vld_count", n_vld - v0, 32'd1);
      rd_chk(32'h08, 32'h1, "rd_ovr_set");
      wr(32'h08, 32'h1);
      rd_chk(32'h08, 32'h0, "rd_ovr_clr");
      frame(0, 0, 127, 0);

      // reset in the middle of a frame
      v0 = n_vld;
      dat_in = pk(0, 0);
      smp = 1'b1;
      tick();
      smp = 1'b0;
      tick();
      tick();
      rstn = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_dat_o", 32'(dat_out), 32'h0);
      check("abort_vld", 32'(vld), 32'h0);
      tick();
      tick();
      rstn = 1'b1;
      repeat (10) tick();
      check("abort_no_vld", n_vld - v0, 32'd0);
      rd_chk(32'h00, 32'hF, "rd_irst_after_abort");
      rd_chk(32'h04, 32'h0, "rd_en_after_abort");
      rd_chk(32'h14, 32'h0, "rd_kp0_after_abort");
      wr(32'h04, 32'h1);
      wr(32'h14, 32'd4096);
      frame(-50, 0, 50, 0);

      // final report
      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
